// File: rtl/spi_fpga_pkg.sv
// Shared constants and FSM state type for the SPI master/slave pair.
package spi_fpga_pkg;

  localparam int unsigned CPOL_IDLE_HIGH      = 1;
  localparam int unsigned CPHA_SAMPLE_LEADING = 0;
  localparam int unsigned MSB_FIRST           = 1;
  localparam int unsigned LSB_FIRST           = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD
  } spi_state_e;

endpackage

// File: rtl/spi_fpga_slave.sv
// SPI slave peer, clocked directly by SCLK edges and framed by CS (active low).
module spi_fpga_slave
  import spi_fpga_pkg::*;
#(
  parameter int PACK_LENGTH                = 8,
  parameter int CPOL                       = 0,
  parameter int CPHA                       = 0,
  parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int PACK_BIT_SEQUENCE_RECEIVE  = 1
) (
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   IN_MOSI,
  input  logic                   IN_CS,
  input  logic                   IN_SCLK,
  input  logic                   IN_RESET,
  output logic                   OUT_MISO,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA
);

  localparam int unsigned BW = $clog2(PACK_LENGTH) + 1;
  localparam logic IDLE_HIGH   = (CPOL == CPOL_IDLE_HIGH);
  localparam logic SAMPLE_LEAD = (CPHA == CPHA_SAMPLE_LEADING);
  localparam logic TX_LSB      = (PACK_BIT_SEQUENCE_TRANSMIT == LSB_FIRST);
  localparam logic RX_MSB      = (PACK_BIT_SEQUENCE_RECEIVE == MSB_FIRST);
  localparam logic [PACK_LENGTH-1:0] ONE = 1;

  logic                   w_lead_clk, w_sample_clk, w_shift_clk, w_frame_clr;
  logic [PACK_LENGTH-1:0] w_tx_seq, w_tx_mask, w_rx_shifted;
  logic [BW-1:0]          w_tx_idx;
  logic                   w_bit_valid;
  logic [BW-1:0]          r_tx_cnt, r_rx_cnt;
  logic [PACK_LENGTH-1:0] r_rx, r_rx_out;

  assign w_lead_clk   = IN_SCLK ^ IDLE_HIGH;
  assign w_sample_clk = SAMPLE_LEAD ? w_lead_clk : ~w_lead_clk;
  assign w_shift_clk  = ~w_sample_clk;
  assign w_frame_clr  = IN_CS | IN_RESET;

  // Transmit word reordered so that element k is the k-th bit on the wire.
  always_comb begin
    w_tx_seq = '0;
    for (int k = 0; k < PACK_LENGTH; k++) begin
      w_tx_seq[k] = TX_LSB ? IN_TRANSMIT_DATA[k] : IN_TRANSMIT_DATA[PACK_LENGTH-1-k];
    end
  end

  // With CPHA=0 bit 0 is presented at CS fall; with CPHA=1 only after the first leading edge.
  assign w_tx_idx    = SAMPLE_LEAD ? r_tx_cnt : r_tx_cnt - BW'(1);
  assign w_bit_valid = SAMPLE_LEAD || (r_tx_cnt != '0);
  assign w_tx_mask   = ONE << w_tx_idx;
  assign OUT_MISO    = ~IN_CS & w_bit_valid & (|(w_tx_seq & w_tx_mask));

  assign w_rx_shifted = RX_MSB ? {r_rx[PACK_LENGTH-2:0], IN_MOSI}
                               : {IN_MOSI, r_rx[PACK_LENGTH-1:1]};

  always_ff @(posedge w_shift_clk or posedge w_frame_clr) begin
    if (w_frame_clr) r_tx_cnt <= '0;
    else             r_tx_cnt <= r_tx_cnt + BW'(1);
  end

  always_ff @(posedge w_sample_clk or posedge w_frame_clr) begin
    if (w_frame_clr) begin
      r_rx     <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_rx     <= w_rx_shifted;
      r_rx_cnt <= r_rx_cnt + BW'(1);
    end
  end

  // Received word survives CS; only reset clears it.
  always_ff @(posedge w_sample_clk or posedge IN_RESET) begin
    if (IN_RESET) r_rx_out <= '0;
    else if (r_rx_cnt == BW'(PACK_LENGTH - 1)) r_rx_out <= w_rx_shifted;
  end

  assign OUT_RECEIVE_DATA = r_rx_out;

endmodule

// File: rtl/spi_fpga_master.sv
// SPI master: one PACK_LENGTH-bit full-duplex word per rising edge of IN_LAUNCH.
module spi_fpga_master
  import spi_fpga_pkg::*;
#(
  parameter int BIT_PER_SECOND             = 12500000,
  parameter int CLOCK_FREQUENCY            = 50000000,
  parameter int PACK_LENGTH                = 8,
  parameter int CPOL                       = 0,
  parameter int CPHA                       = 0,
  parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int PACK_BIT_SEQUENCE_RECEIVE  = 1
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic                   IN_LAUNCH,
  input  logic [PACK_LENGTH-1:0] IN_DATA,
  input  logic                   IN_MISO,
  output logic                   OUT_MOSI,
  output logic                   OUT_CS,
  output logic                   OUT_SCLK,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_ACTION_DONE
);

  localparam int unsigned H  = CLOCK_FREQUENCY / (2 * BIT_PER_SECOND);
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned BW = $clog2(PACK_LENGTH) + 1;
  localparam logic IDLE_LEVEL  = (CPOL == CPOL_IDLE_HIGH);
  localparam logic SAMPLE_LEAD = (CPHA == CPHA_SAMPLE_LEADING);
  localparam logic TX_MSB      = (PACK_BIT_SEQUENCE_TRANSMIT == MSB_FIRST);
  localparam logic RX_MSB      = (PACK_BIT_SEQUENCE_RECEIVE == MSB_FIRST);
  localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);
  // Sampled-bit count seen at the final trailing edge.
  localparam logic [BW-1:0] BITS_LAST = SAMPLE_LEAD ? BW'(PACK_LENGTH) : BW'(PACK_LENGTH - 1);

  spi_state_e             r_state;
  logic                   r_launch_q, r_cs, r_sclk, r_mosi, r_done;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [PACK_LENGTH-1:0] r_tx, r_rx, r_rx_out;

  logic                   w_launch_edge, w_cnt_done, w_leading, w_last_edge;
  logic                   w_sample_edge, w_shift_edge, w_data_head, w_mosi_next;
  logic [PACK_LENGTH-1:0] w_tx_shifted, w_rx_shifted;

  assign w_launch_edge = IN_LAUNCH & ~r_launch_q;
  assign w_cnt_done    = (r_cnt == CNT_LAST);
  assign w_leading     = (r_sclk == IDLE_LEVEL);
  assign w_last_edge   = ~w_leading & (r_bit_cnt == BITS_LAST);
  assign w_sample_edge = (w_leading == SAMPLE_LEAD);
  assign w_shift_edge  = ~w_sample_edge & ~w_last_edge;

  assign w_data_head  = TX_MSB ? IN_DATA[PACK_LENGTH-1] : IN_DATA[0];
  assign w_tx_shifted = TX_MSB ? {r_tx[PACK_LENGTH-2:0], 1'b0} : {1'b0, r_tx[PACK_LENGTH-1:1]};
  // CPHA=0 already shows the head bit, so the next bit comes from the shifted word.
  assign w_mosi_next  = SAMPLE_LEAD ? (TX_MSB ? w_tx_shifted[PACK_LENGTH-1] : w_tx_shifted[0])
                                    : (TX_MSB ? r_tx[PACK_LENGTH-1] : r_tx[0]);
  assign w_rx_shifted = RX_MSB ? {r_rx[PACK_LENGTH-2:0], IN_MISO} : {IN_MISO, r_rx[PACK_LENGTH-1:1]};

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_state    <= ST_IDLE;
      r_launch_q <= 1'b0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= IDLE_LEVEL;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_out   <= '0;
    end else begin
      r_launch_q <= IN_LAUNCH;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch_edge) begin
            r_state   <= ST_SETUP;
            r_cs      <= 1'b0;
            r_tx      <= IN_DATA;
            r_rx      <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_mosi    <= SAMPLE_LEAD ? w_data_head : 1'b0;
          end else begin
            r_mosi <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= ST_TRANSFER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_TRANSFER: begin
          if (w_cnt_done) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            if (w_sample_edge) begin
              r_rx      <= w_rx_shifted;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (w_shift_edge) begin
              r_tx   <= w_tx_shifted;
              r_mosi <= w_mosi_next;
            end
            if (w_last_edge) r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
            r_cs     <= 1'b1;
            r_mosi   <= 1'b0;
            r_rx_out <= r_rx;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign OUT_MOSI         = r_mosi;
  assign OUT_CS           = r_cs;
  assign OUT_SCLK         = r_sclk;
  assign OUT_RECEIVE_DATA = r_rx_out;
  assign OUT_ACTION_DONE  = r_done;

endmodule

// File: tb/tb_spi_fpga_master.sv
// Four master/slave pairs in different modes run side by side on shared launch/reset.
module tb_spi_fpga_master;

  localparam int NL = 4;
  // Lane 0: CPOL1/CPHA0, master RX LSB-first, slave TX LSB-first; lanes 1..3 MSB-first.
  localparam logic [NL-1:0] LCPOL = 4'b1001;
  localparam logic [NL-1:0] LCPHA = 4'b1010;
  localparam logic [NL-1:0] LMTX  = 4'b1111;
  localparam logic [NL-1:0] LMRX  = 4'b1110;
  localparam logic [NL-1:0] LSTX  = 4'b1110;
  localparam logic [NL-1:0] LSRX  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       launch = 1'b0;
  logic       mon_clr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] s_data = 8'h00;

  logic       w_mosi [NL];
  logic       w_miso [NL];
  logic       w_cs   [NL];
  logic       w_sclk [NL];
  logic       w_done [NL];
  logic [7:0] m_rx   [NL];
  logic [7:0] s_rx   [NL];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_cs_low[NL], mon_lead[NL], mon_edges[NL], mon_done[NL], mon_bad_per[NL], mon_last[NL];
  logic prev_sclk[NL];
  logic [7:0] prev_m[NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int CP  = LCPOL[g] ? 1 : 0;
    localparam int CH  = LCPHA[g] ? 1 : 0;
    localparam int MTX = LMTX[g] ? 1 : 0;
    localparam int MRX = LMRX[g] ? 1 : 0;
    localparam int STX = LSTX[g] ? 1 : 0;
    localparam int SRX = LSRX[g] ? 1 : 0;

    spi_fpga_master #(
      .CPOL(CP), .CPHA(CH),
      .PACK_BIT_SEQUENCE_TRANSMIT(MTX), .PACK_BIT_SEQUENCE_RECEIVE(MRX)
    ) u_master (
      .IN_CLOCK(clk), .IN_RESET(rst), .IN_LAUNCH(launch), .IN_DATA(m_data),
      .IN_MISO(w_miso[g]), .OUT_MOSI(w_mosi[g]), .OUT_CS(w_cs[g]), .OUT_SCLK(w_sclk[g]),
      .OUT_RECEIVE_DATA(m_rx[g]), .OUT_ACTION_DONE(w_done[g])
    );

    spi_fpga_slave #(
      .PACK_LENGTH(8), .CPOL(CP), .CPHA(CH),
      .PACK_BIT_SEQUENCE_TRANSMIT(STX), .PACK_BIT_SEQUENCE_RECEIVE(SRX)
    ) u_slave (
      .IN_TRANSMIT_DATA(s_data), .IN_MOSI(w_mosi[g]), .IN_CS(w_cs[g]), .IN_SCLK(w_sclk[g]),
      .IN_RESET(rst), .OUT_MISO(w_miso[g]), .OUT_RECEIVE_DATA(s_rx[g])
    );
  end

  // Bus monitor: CS-low time, SCLK edges and leading-edge spacing, done pulses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < NL; l++) begin
      if (mon_clr) begin
        mon_cs_low[l] = 0; mon_lead[l] = 0; mon_edges[l] = 0;
        mon_done[l] = 0; mon_bad_per[l] = 0; mon_last[l] = 0;
      end else begin
        if (!w_cs[l]) mon_cs_low[l]++;
        if (w_done[l]) mon_done[l]++;
        if (w_sclk[l] !== prev_sclk[l]) begin
          mon_edges[l]++;
          if (w_sclk[l] !== LCPOL[l]) begin
            if (mon_lead[l] > 0 && (cyc - mon_last[l]) != 4) mon_bad_per[l]++;
            mon_lead[l]++;
            mon_last[l] = cyc;
          end
        end
      end
      prev_sclk[l] = w_sclk[l];
    end
  end

  // Expected received word from the wire bit order alone.
  function automatic logic [7:0] model(input logic [7:0] d, input logic tx_msb, input logic rx_msb);
    logic [7:0] r;
    logic b;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      b = tx_msb ? d[7-k] : d[k];
      if (rx_msb) r[7-k] = b;
      else        r[k]   = b;
    end
    return r;
  endfunction

  task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0h expected %0h", name, lane, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] md, input logic [7:0] sd, input int hold,
                      input logic [7:0] exp_m0, input logic [7:0] exp_s0);
    logic [7:0] em, es;
    m_data = md; s_data = sd;
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    launch = 1'b1;
    for (int n = 1; n <= hold + 45; n++) begin
      tick();
      if (n == hold) launch = 1'b0;
      if (n == 10)
        for (int l = 0; l < NL; l++) check("rx_held_mid", l, 32'(m_rx[l]), 32'(prev_m[l]));
    end
    for (int l = 0; l < NL; l++) begin
      em = (l == 0) ? exp_m0 : model(sd, LSTX[l], LMRX[l]);
      es = (l == 0) ? exp_s0 : model(md, LMTX[l], LSRX[l]);
      check("master_rx", l, 32'(m_rx[l]), 32'(em));
      check("slave_rx", l, 32'(s_rx[l]), 32'(es));
      check("done_pulses", l, mon_done[l], 1);
      check("cs_low_clks", l, mon_cs_low[l], 36);
      check("sclk_pulses", l, mon_lead[l], 8);
      check("sclk_period", l, mon_bad_per[l], 0);
      check("cs_idle", l, 32'(w_cs[l]), 1);
      check("sclk_idle", l, 32'(w_sclk[l]), 32'(LCPOL[l]));
      check("mosi_idle", l, 32'(w_mosi[l]), 0);
      prev_m[l] = em;
    end
  endtask

  typedef struct {
    logic [7:0] m_data;
    logic [7:0] s_data;
    int         hold;
    logic [7:0] exp_m_rx0;
    logic [7:0] exp_s_rx0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    logic [7:0] rm, rs;
    vecs[0] = '{8'hEA, 8'h53, 6,   8'h53, 8'hEA};
    vecs[1] = '{8'hA5, 8'h3C, 6,   8'h3C, 8'hA5};
    vecs[2] = '{8'hFF, 8'h00, 3,   8'h00, 8'hFF};
    vecs[3] = '{8'h00, 8'hFF, 3,   8'hFF, 8'h00};
    vecs[4] = '{8'h5A, 8'hC3, 100, 8'hC3, 8'h5A};
    vecs[5] = '{8'h96, 8'h69, 2,   8'h69, 8'h96};
    for (int l = 0; l < NL; l++) prev_m[l] = 8'h00;

    #1 rst = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < NL; l++) begin
      check("rst_cs", l, 32'(w_cs[l]), 1);
      check("rst_sclk", l, 32'(w_sclk[l]), 32'(LCPOL[l]));
      check("rst_mosi", l, 32'(w_mosi[l]), 0);
      check("rst_done", l, 32'(w_done[l]), 0);
      check("rst_mrx", l, 32'(m_rx[l]), 0);
      check("rst_srx", l, 32'(s_rx[l]), 0);
    end
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++)
      xfer(vecs[i].m_data, vecs[i].s_data, vecs[i].hold, vecs[i].exp_m_rx0, vecs[i].exp_s_rx0);

    for (int i = 0; i < 6; i++) begin
      rm = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      xfer(rm, rs, int'($urandom_range(1, 20)), model(rs, LSTX[0], LMRX[0]), model(rm, LMTX[0], LSRX[0]));
    end

    // Reset at the fifth SCLK edge aborts the frame without a done pulse.
    m_data = 8'h3E; s_data = 8'hB1;
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    launch = 1'b1;
    n = 0;
    while (mon_edges[0] < 5 && n < 100) begin
      tick();
      n++;
      if (n == 3) launch = 1'b0;
    end
    check("edge5_reached", 0, 32'(mon_edges[0] >= 5), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int l = 0; l < NL; l++) begin
      check("abort_cs", l, 32'(w_cs[l]), 1);
      check("abort_sclk", l, 32'(w_sclk[l]), 32'(LCPOL[l]));
      check("abort_mrx", l, 32'(m_rx[l]), 0);
      check("abort_srx", l, 32'(s_rx[l]), 0);
      prev_m[l] = 8'h00;
    end
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    repeat (60) tick();
    for (int l = 0; l < NL; l++) begin
      check("abort_no_done", l, mon_done[l], 0);
      check("abort_cs_stays", l, mon_cs_low[l], 0);
    end

    xfer(8'hC6, 8'h2D, 4, model(8'h2D, LSTX[0], LMRX[0]), model(8'hC6, LMTX[0], LSRX[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
